lfsr_seg_checker: RTL

Receive-side checker for the 8-bit LFSR pseudo-random display stream. It samples a pair of active-low seven-segment hex codes (high nibble, low nibble) and decodes them back to a byte. It locks onto the LFSR sequence x⁸ feedback = b4^b3^b2^b0, shift right, then counts mismatches while locked. It sits on the far end of the generator's segment outputs, for self-test of the display path on the board.

---
 rtl/lfsr_seg_checker_pkg.sv | 47 ++++
 rtl/lfsr_seg_checker_if.sv | 14 +
 rtl/lfsr_seg_checker_seg7_to_hex.sv | 37 +++
 rtl/lfsr_seg_checker.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/lfsr_seg_checker_pkg.sv
// Shared definitions for the LFSR segment-stream checker.
// Holds the seven-segment code constants, the LFSR next-value function,
// the checker state enum and the captured sample payload.
package lfsr_seg_checker_pkg;

   localparam int unsigned SEG_W  = 7;
   localparam int unsigned NIB_W  = 4;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W  = 4;

   // Active-low segment codes, bit order {g,f,e,d,c,b,a}
   localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
   localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
   localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
   localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
   localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
   localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_9 = 7'b0010000;
   localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
   localparam logic [SEG_W-1:0] SEG_B = 7'b0000011;
   localparam logic [SEG_W-1:0] SEG_C = 7'b1000110;
   localparam logic [SEG_W-1:0] SEG_D = 7'b0100001;
   localparam logic [SEG_W-1:0] SEG_E = 7'b0000110;
   localparam logic [SEG_W-1:0] SEG_F = 7'b0001110;

   // Feedback taps b4, b3, b2, b0
   localparam logic [BYTE_W-1:0] LFSR_TAPS = 8'b0001_1101;

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } state_t;

   typedef struct packed {
      logic [SEG_W-1:0] seg_h;
      logic [SEG_W-1:0] seg_l;
   } seg_pair_t;

   // Next LFSR value: shift right, feedback into the MSB
   function automatic logic [BYTE_W-1:0] lfsr_pred(input logic [BYTE_W-1:0] b);
      return {^(b & LFSR_TAPS), b[BYTE_W-1:1]};
   endfunction

endpackage

// File: rtl/lfsr_seg_checker_if.sv
// Sample bus from the segment display path into the checker.
//   in_valid : sample strobe
//   seg_H    : active-low segment code, high nibble
//   seg_L    : active-low segment code, low nibble
interface lfsr_seg_checker_if;
   import lfsr_seg_checker_pkg::*;

   logic             in_valid;
   logic [SEG_W-1:0] seg_H;
   logic [SEG_W-1:0] seg_L;

   modport master (output in_valid, output seg_H, output seg_L);
   modport slave  (input  in_valid, input  seg_H, input  seg_L);
endinterface

// File: rtl/lfsr_seg_checker_seg7_to_hex.sv
// Combinational seven-segment to hex decoder.
//   seg     : active-low code {g,f,e,d,c,b,a}
//   nib_c   : decoded nibble (0 for an illegal code)
//   valid_c : 1 when seg is one of the 16 hex glyphs
module seg7_to_hex
   import lfsr_seg_checker_pkg::*;
(
   input  logic [SEG_W-1:0] seg,
   output logic [NIB_W-1:0] nib_c,
   output logic             valid_c
);

   always_comb begin
      nib_c   = '0;
      valid_c = 1'b1;
      case (seg)
         SEG_0:   nib_c = 4'h0;
         SEG_1:   nib_c = 4'h1;
         SEG_2:   nib_c = 4'h2;
         SEG_3:   nib_c = 4'h3;
         SEG_4:   nib_c = 4'h4;
         SEG_5:   nib_c = 4'h5;
         SEG_6:   nib_c = 4'h6;
         SEG_7:   nib_c = 4'h7;
         SEG_8:   nib_c = 4'h8;
         SEG_9:   nib_c = 4'h9;
         SEG_A:   nib_c = 4'hA;
         SEG_B:   nib_c = 4'hB;
         SEG_C:   nib_c = 4'hC;
         SEG_D:   nib_c = 4'hD;
         SEG_E:   nib_c = 4'hE;
         SEG_F:   nib_c = 4'hF;
         default: valid_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/lfsr_seg_checker.sv
// Receive-side checker for the 8-bit LFSR seven-segment stream.
// Captures a segment pair, decodes it to a byte, locks onto the LFSR
// sequence and counts mismatches while locked.
//   clk, clrn : clock, async active-low reset
//   smp       : sample bus (in_valid, seg_H, seg_L)
//   value     : last decoded byte
//   locked    : high while in LOCKED
//   err_pulse : one-cycle pulse per counted error
//   bad_seg   : one-cycle pulse for a non-hex segment code
//   err_cnt   : saturating error count
module lfsr_seg_checker
   import lfsr_seg_checker_pkg::*;
#(
   parameter int unsigned LOCK_CNT = 4,
   parameter int unsigned LOSS_CNT = 3,
   parameter int unsigned ERR_W    = 16
) (
   input  logic                clk,
   input  logic                clrn,
   lfsr_seg_checker_if.slave   smp,
   output logic [BYTE_W-1:0]   value,
   output logic                locked,
   output logic                err_pulse,
   output logic                bad_seg,
   output logic [ERR_W-1:0]    err_cnt
);

   logic              cap_valid;
   seg_pair_t         cap;
   state_t            state, state_n;
   logic [BYTE_W-1:0] exp_q, exp_n;
   logic [CNT_W-1:0]  match_cnt, match_n;
   logic [CNT_W-1:0]  miss_cnt, miss_n;
   logic              err_c;

   logic [NIB_W-1:0]  nib_h_c, nib_l_c;
   logic              ok_h_c, ok_l_c;
   logic [BYTE_W-1:0] byte_c;
   logic              seg_ok_c;
   logic              usable_c;
   logic [CNT_W-1:0]  miss_inc_c;

   // Input capture stage
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         cap_valid <= 1'b0;
         cap       <= '0;
      end else begin
         cap_valid <= smp.in_valid;
         if (smp.in_valid) cap <= '{seg_h: smp.seg_H, seg_l: smp.seg_L};
      end
   end

   seg7_to_hex u_dec_h (.seg(cap.seg_h), .nib_c(nib_h_c), .valid_c(ok_h_c));
   seg7_to_hex u_dec_l (.seg(cap.seg_l), .nib_c(nib_l_c), .valid_c(ok_l_c));

   assign byte_c     = {nib_h_c, nib_l_c};
   assign seg_ok_c   = ok_h_c & ok_l_c;
   // 0x00 never occurs in the LFSR sequence, so it is never a usable sample
   assign usable_c   = seg_ok_c && (byte_c != '0);
   assign miss_inc_c = miss_cnt + CNT_W'(1);

   // FSM and counter state register
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state     <= SEARCH;
         exp_q     <= '0;
         match_cnt <= '0;
         miss_cnt  <= '0;
      end else begin
         state     <= state_n;
         exp_q     <= exp_n;
         match_cnt <= match_n;
         miss_cnt  <= miss_n;
      end
   end

   // Next-state logic
   always_comb begin
      state_n = state;
      exp_n   = exp_q;
      match_n = match_cnt;
      miss_n  = miss_cnt;
      err_c   = 1'b0;
      if (cap_valid) begin
         case (state)
            SEARCH: begin
               if (!usable_c) begin
                  match_n = '0;
               end else begin
                  exp_n = lfsr_pred(byte_c);
                  if ((byte_c == exp_q) && (match_cnt != '0)) begin
                     // This match would take the count to LOCK_CNT+1
                     if (match_cnt == CNT_W'(LOCK_CNT)) begin
                        state_n = LOCKED;
                        miss_n  = '0;
                     end else begin
                        match_n = match_cnt + CNT_W'(1);
                     end
                  end else begin
                     match_n = CNT_W'(1);
                  end
               end
            end
            LOCKED: begin
               // Flywheel: expectation advances regardless of the sample
               exp_n = lfsr_pred(exp_q);
               if (usable_c && (byte_c == exp_q)) begin
                  miss_n = '0;
               end else begin
                  err_c  = 1'b1;
                  miss_n = miss_inc_c;
                  if (miss_inc_c == CNT_W'(LOSS_CNT)) begin
                     state_n = SEARCH;
                     match_n = '0;
                  end
               end
            end
            default: state_n = SEARCH;
         endcase
      end
   end

   // Registered outputs
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         value     <= '0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
         bad_seg   <= 1'b0;
         err_cnt   <= '0;
      end else begin
         if (cap_valid) value <= byte_c;
         locked    <= (state_n == LOCKED);
         err_pulse <= err_c;
         bad_seg   <= cap_valid & ~seg_ok_c;
         if (err_c && (err_cnt != '1)) err_cnt <= err_cnt + ERR_W'(1);
      end
   end

endmodule
